// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan sequencer: FSM state encoding and
// settle counter width.
package mux_scan_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DONE    = 3'd4
  } scan_state_t;

endpackage

// File: rtl/mux_scan_settle_cnt.sv
// Loadable down-counter with zero flag; times the settle window after each
// select change.
module mux_scan_settle_cnt
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mux_scan_seq.sv
// Mux scan sequencer: steps select over DEPTH channels, waits SETTLE cycles,
// captures muxout and offers (chanOut, dataOut) downstream. Define
// SCAN_CONT_EN for free-running scans that restart without a new start.
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter int BIT_WIDTH = 2,
  parameter int DEPTH     = 4,
  parameter int SEL_WIDTH = 2,
  parameter int SETTLE    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [SEL_WIDTH-1:0] select,
  input  logic [BIT_WIDTH-1:0] muxout,
  output logic [BIT_WIDTH-1:0] dataOut,
  output logic [SEL_WIDTH-1:0] chanOut,
  output logic                 valid,
  input  logic                 ready,
  output logic                 busy,
  output logic                 done,
  output scan_state_t          scan_state
);

`ifdef SCAN_CONT_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  localparam logic [SEL_WIDTH-1:0] LAST_SEL  = SEL_WIDTH'(DEPTH - 1);
  localparam logic [CNT_W-1:0]     SETTLE_LD = CNT_W'(SETTLE - 1);

  scan_state_t state;
  logic        accept;
  logic        last_chan;
  logic        cnt_load;
  logic        cnt_zero;

  // Handshake: a word transfers on a rising edge where valid && ready; while
  // valid && !ready, dataOut/chanOut/valid (and select) are frozen.
  assign accept    = (state == ST_HOLD) && valid && ready;
  assign last_chan = (select == LAST_SEL);
  assign cnt_load  = ((state == ST_IDLE) && start) ||
                     (accept && (!last_chan || CONT));

  mux_scan_settle_cnt u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (SETTLE_LD),
    .dec      (state == ST_SETTLE),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      select  <= '0;
      dataOut <= '0;
      chanOut <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          select <= '0;
          if (start) begin
            state <= ST_SETTLE;
            busy  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_zero) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          dataOut <= muxout;
          chanOut <= select;
          valid   <= 1'b1;
          state   <= ST_HOLD;
        end
        ST_HOLD: begin
          if (accept) begin
            valid <= 1'b0;
            if (last_chan) begin
              select <= '0;
              // Free-running mode flags the end of a pass and restarts at once
              if (CONT) begin
                done  <= 1'b1;
                state <= ST_SETTLE;
              end else begin
                state <= ST_DONE;
              end
            end else begin
              select <= select + SEL_WIDTH'(1);
              state  <= ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign scan_state = state;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Bench for mux_scan_seq: randomized scans against a word-queue model of one
// scan, plus backpressure, mid-scan reset and a DEPTH=3 wrap instance.
module tb_mux_scan_seq;
  import mux_scan_pkg::*;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        ready;
  logic [1:0]  select;
  logic [1:0]  muxout;
  logic [1:0]  dataOut;
  logic [1:0]  chanOut;
  logic        valid;
  logic        busy;
  logic        done;
  scan_state_t scan_state;

  logic        start3;
  logic        ready3;
  logic [1:0]  select3;
  logic [1:0]  muxout3;
  logic [1:0]  dataOut3;
  logic [1:0]  chanOut3;
  logic        valid3;
  logic        busy3;
  logic        done3;
  scan_state_t scan_state3;

  logic [7:0]  data_in;
  logic [3:0]  exp_q[$];
  int          total;
  int          bad;

  // Behavioural mux: channel k is data_in[2k+1:2k]
  assign muxout  = data_in[select*2 +: 2];
  assign muxout3 = data_in[select3*2 +: 2];

  mux_scan_seq #(.BIT_WIDTH(2), .DEPTH(DEPTH), .SEL_WIDTH(2), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .select(select), .muxout(muxout),
    .dataOut(dataOut), .chanOut(chanOut), .valid(valid), .ready(ready),
    .busy(busy), .done(done), .scan_state(scan_state)
  );

  mux_scan_seq #(.BIT_WIDTH(2), .DEPTH(3), .SEL_WIDTH(2), .SETTLE(SETTLE)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .select(select3), .muxout(muxout3),
    .dataOut(dataOut3), .chanOut(chanOut3), .valid(valid3), .ready(ready3),
    .busy(busy3), .done(done3), .scan_state(scan_state3)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_select"}, select, 0);
    check({tag, "_data"}, dataOut, 0);
    check({tag, "_chan"}, chanOut, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_state"}, scan_state, ST_IDLE);
  endtask

  // mode 0: random ready, 1: ready high, 2: 5-cycle stall on channel 1
  task automatic run_scan(input int mode);
    logic [7:0] saved;
    logic [3:0] w;
    logic       pre_valid;
    logic [1:0] pre_data;
    logic [1:0] pre_chan;
    int         since;
    int         edges;
    int         done_seen;
    int         hold_cnt;
    saved   = 8'($urandom);
    data_in = saved;
    exp_q.delete();
    for (int c = 0; c < DEPTH; c++) exp_q.push_back({c[1:0], saved[c*2 +: 2]});
    check("idle_busy", busy, 0);
    check("idle_state", scan_state, ST_IDLE);
    start = 1'b1;
    ready = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    step();
    start     = 1'b0;
    since     = 0;
    edges     = 0;
    done_seen = 0;
    hold_cnt  = 0;
    check("busy_rise", busy, 1);
    while (done_seen == 0 && edges < 200) begin
      pre_valid = valid;
      pre_data  = dataOut;
      pre_chan  = chanOut;
      case (mode)
        0: ready = 1'($urandom_range(0, 1));
        1: ready = 1'b1;
        default: begin
          if (valid && chanOut == 2'd1 && hold_cnt < 5) begin
            ready = 1'b0;
            hold_cnt++;
            data_in = 8'($urandom);
          end else begin
            ready   = 1'b1;
            data_in = saved;
          end
        end
      endcase
      start = ($urandom_range(0, 3) == 0);
      step();
      edges++;
      since++;
      if (pre_valid && ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", exp_q.size(), 1);
        end else begin
          w = exp_q.pop_front();
          check("word_chan", pre_chan, w[3:2]);
          check("word_data", pre_data, w[1:0]);
        end
        since = 0;
      end else if (pre_valid) begin
        check("hold_valid", valid, 1);
        check("hold_data", dataOut, pre_data);
        check("hold_chan", chanOut, pre_chan);
        check("hold_select", select, pre_chan);
      end
      if (valid && !pre_valid) check("valid_lat", since, SETTLE + 1);
      if (valid) check("sel_track", select, chanOut);
      if (done) begin
        done_seen = 1;
        check("done_lat", since, 1);
        check("done_busy", busy, 0);
        check("done_state", scan_state, ST_IDLE);
        check("done_words", exp_q.size(), 0);
        check("done_select", select, 0);
        if (mode == 1) check("scan_len", edges, DEPTH * (SETTLE + 2) + 1);
      end else begin
        check("busy_hold", busy, 1);
      end
    end
    start   = 1'b0;
    ready   = 1'b0;
    data_in = saved;
    check("done_seen", done_seen, 1);
    step();
    check("done_pulse", done, 0);
    check("post_idle", busy, 0);
  endtask

  task automatic reset_mid_scan();
    data_in = 8'($urandom);
    ready   = 1'b1;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 60 && !(valid && chanOut == 2'd2); i++) step();
    check("rst_reach_ch2", chanOut, 2);
    ready = 1'b0;
    step();
    check("rst_hold_valid", valid, 1);
    rst_n = 1'b0;
    start = 1'b1;
    step();
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("midrst_no_done", done, 0);
      check("midrst_no_busy", busy, 0);
    end
    ready = 1'b0;
  endtask

  task automatic depth3_scan();
    logic [1:0] got_q[$];
    logic       pre_v;
    logic [1:0] pre_c;
    logic [1:0] pre_d;
    int         seen;
    data_in = 8'($urandom);
    start3  = 1'b1;
    step();
    start3 = 1'b0;
    seen   = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      pre_v = valid3;
      pre_c = chanOut3;
      pre_d = dataOut3;
      step();
      check("d3_sel_range", 32'(select3 < 2'd3), 1);
      if (pre_v) begin
        got_q.push_back(pre_c);
        check("d3_data", pre_d, data_in[pre_c*2 +: 2]);
      end
      if (done3) seen = 1;
    end
    check("d3_done", seen, 1);
    check("d3_words", got_q.size(), 3);
    for (int i = 0; i < got_q.size() && i < 3; i++) check("d3_chan", got_q[i], i);
    check("d3_sel_wrap", select3, 0);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    ready   = 1'b0;
    start3  = 1'b0;
    ready3  = 1'b1;
    data_in = 8'b00011011;
    step();
    step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();
    check("idle_select", select, 0);

    depth3_scan();
    run_scan(1);
    run_scan(2);
    reset_mid_scan();
    run_scan(1);
    for (int n = 0; n < 6; n++) run_scan(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
